cic_upsample_integrator: RTL and testbench
==========================================

# cic_upsample_integrator

Rate-changing integrator section of the CIC interpolation filter. It sits downstream of the comb cascade. It accepts one low-rate comb output sample every R high-rate cycles, zero-stuffs it up to the high rate, and runs it through N cascaded, pipelined integrators. A valid/ready handshake on both sides lets the DAC-side consumer stall the chain.

## Interface
- R, default 4: interpolation ratio; legal range 2–255.
- N, default 3: number of integrator stages; legal range 1–8.
- IN_W, default 32: input sample width, signed two's complement.
- OUT_W, default 40: accumulator and output width, signed; must be ≥ IN_W.

- clk, input, 1: single clock; all state changes on its rising edge.
- rst, input, 1: asynchronous, active-low reset.
- d_in, input, IN_W: low-rate sample from the comb cascade.
- in_valid, input, 1: d_in holds a sample.
- in_ready, output, 1: the block accepts d_in this cycle.
- d_out, output, OUT_W: high-rate filtered sample.
- out_valid, output, 1: d_out is valid.
- out_ready, input, 1: the consumer takes d_out this cycle.

## Operation
- **Reset values (rst=0):** all accumulators are 0, phase = 0, fill counter = 0, d_out = 0, out_valid = 0. in_ready is combinational and reads 0 while in reset.
- **State machine:**
  - IDLE: the block has not yet received a sample since reset; it moves to RUN on the first accepted input.
  - RUN: steady operation; the block stays here until reset.
  - Reset asserted mid-operation returns the block to IDLE with all state cleared. Any in-flight samples are discarded.
- **Advance condition:** adv = (~out_valid | out_ready) & (phase≠0 | in_valid).
  - The whole chain, the phase counter and the fill counter move only on adv.
- **Input handshake:** in_ready = (phase==0) & (~out_valid | out_ready).
  - A transfer occurs when in_valid & in_ready.
  - in_ready is 0 for phases 1..R-1.
- **Injected value:** x = sign_extend(d_in) when phase==0, otherwise 0 (zero stuffing).
- **On adv:**
  - acc[0] ← acc[0] + x.
  - acc[k] ← acc[k] + acc[k-1] for k = 1..N-1, using the pre-edge acc[k-1]. Each stage is registered.
  - phase ← (phase==R-1) ? 0 : phase+1.
- **Input underrun:** if phase==0 and in_valid==0, there is no advance. The chain holds and zeros are never substituted for a missing sample.
- **Output:**
  - d_out = acc[N-1].
  - out_valid is set on the adv that brings the fill counter to N, and stays set from then on.
  - While out_valid=1 and out_ready=0, d_out and out_valid hold stable.
- **Arithmetic:** all adds are OUT_W-bit two's complement with silent wrap-around and no saturation. Wrap is correct CIC behaviour provided OUT_W covers the filter's total bit growth. The integrator section never detects overflow.
- **Simultaneous events:** out_ready=1 and an input transfer in the same cycle produce one advance. Output is consumed and the new sample is injected on the same edge.

## Timing
- A sample accepted at edge t reaches acc[0] at t; its first contribution appears on d_out after N advances.
- Throughput is one output per cycle when in_valid is presented every R-th advance and out_ready=1.
- The block accepts one input per R advances.
- in_ready depends combinationally on out_valid, out_ready and phase. There is no combinational path from in_valid to in_ready.

## Structure
- Shared package cic_pkg holds:
  - the signed sample typedefs;
  - a bit-growth function, growth(R, M, N) = N·log2(R·M), rounded up;
  - the legal-range constants for R and N.
  The comb cascade and this block both use the package.
- One sub-module, cic_integrator_stage: a single OUT_W-bit registered accumulator with an enable input (adv) and asynchronous active-low clear. It is instantiated N times with a generate loop.
- The top level holds the phase counter, fill counter, FSM and handshake logic.

## Test plan
- **Impulse:** R=2, N=3, out_ready=1; d_in = 1 then 0 continuously, in_valid held high.
  - After the N-advance fill, d_out = 1, 3, 6, 10, 15, 21 on consecutive cycles.
- **Step:** R=2, N=1; d_in = 1 constant.
  - d_out = 1, 1, 2, 2, 3, 3; in_ready high every second cycle only.
- **Back-pressure:** during the impulse test, drop out_ready for 5 cycles.
  - d_out holds its value, in_ready = 0 throughout, and the sequence resumes unbroken afterwards.
- **Underrun:** R=4, N=1; deassert in_valid for 3 cycles at phase 0.
  - No advance and out_valid stays unchanged; after in_valid returns, the output matches the uninterrupted reference.
- **Wrap-around:** OUT_W=8, IN_W=8, R=2, N=1; d_in = 127 constant.
  - d_out = 127, 127, -2, -2.
- **Reset mid-stream:** pull rst low for one cycle during the impulse test.
  - All outputs clear immediately (out_valid=0, d_out=0); the next impulse reproduces 1, 3, 6, 10 after a fresh N-advance fill.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared CIC definitions: sample types, legal parameter ranges and the
// bit-growth helper used to size accumulators across the CIC sections.
package cic_pkg;

  // Legal parameter ranges for the interpolation ratio and stage count.
  localparam int unsigned CIC_R_MIN = 2;
  localparam int unsigned CIC_R_MAX = 255;
  localparam int unsigned CIC_N_MIN = 1;
  localparam int unsigned CIC_N_MAX = 8;

  // Default sample widths shared by the comb and integrator sections.
  localparam int unsigned CIC_IN_W  = 32;
  localparam int unsigned CIC_OUT_W = 40;

  typedef logic signed [CIC_IN_W-1:0]  cic_sample_t;
  typedef logic signed [CIC_OUT_W-1:0] cic_acc_t;

  // Integrator-section control state.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } cic_state_e;

  // Bit growth N*log2(R*M), rounded up: the smallest g with 2^g >= (R*M)^N.
  function automatic int unsigned growth(input int unsigned r,
                                         input int unsigned m,
                                         input int unsigned n);
    logic [127:0] target;
    logic [127:0] pw;
    int unsigned  g;
    target = 128'd1;
    for (int i = 0; i < int'(n); i++) begin
      target = target * 128'(r * m);
    end
    pw = 128'd1;
    g  = 0;
    for (int i = 0; i < 127; i++) begin
      if (pw < target) begin
        pw = {pw[126:0], 1'b0};
        g  = g + 1;
      end else begin
        pw = pw;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/cic_upsample_integrator_if.sv
// Streaming bus of the integrator section: low-rate samples in, high-rate
// filtered samples out, each side with its own valid/ready handshake.
interface cic_upsample_integrator_if #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 40
);
  logic signed [IN_W-1:0]  d_in;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [OUT_W-1:0] d_out;
  logic                    out_valid;
  logic                    out_ready;

  // Producer/consumer side that feeds samples and drains results.
  modport master (
    output d_in, in_valid, out_ready,
    input  in_ready, d_out, out_valid
  );

  // The integrator block itself.
  modport slave (
    input  d_in, in_valid, out_ready,
    output in_ready, d_out, out_valid
  );
endinterface

// File: rtl/cic_integrator_stage.sv
// One integrator stage: a registered wrap-around accumulator that adds its
// upstream value whenever the chain advances.
module cic_integrator_stage #(
  parameter int unsigned W = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                adv,
  input  logic signed [W-1:0] addend,
  output logic signed [W-1:0] acc
);

  logic signed [W-1:0] acc_r;

  // Accumulate on advance, otherwise hold; adds wrap silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r <= {W{1'b0}};
    end else if (adv) begin
      acc_r <= acc_r + addend;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/cic_upsample_integrator_chk.sv
// Protocol properties of the integrator section's output side.
module cic_upsample_integrator_chk #(
  parameter int unsigned OUT_W = 40
) (
  input logic                    clk,
  input logic                    rst,
  input logic                    out_valid,
  input logic                    out_ready,
  input logic                    in_ready,
  input logic                    phase_zero,
  input logic                    running,
  input logic signed [OUT_W-1:0] d_out
);

  // A stalled output keeps both its data and its valid flag.
  a_stall_hold: assert property (@(posedge clk) disable iff (!rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(d_out)));

  // Inputs are only offered at the start of an interpolation period.
  a_ready_phase: assert property (@(posedge clk) disable iff (!rst)
    in_ready |-> phase_zero);

  // Output can only be valid once the first sample has been taken.
  a_valid_run: assert property (@(posedge clk) disable iff (!rst)
    out_valid |-> running);

endmodule

// File: rtl/cic_upsample_integrator.sv
// CIC interpolator integrator section: zero-stuffs each accepted low-rate
// sample to R high-rate slots and feeds it through N pipelined integrators.
// The whole pipe moves as one unit on "advance", so a stalled consumer
// freezes every stage, the phase counter and the fill counter together.
module cic_upsample_integrator
  import cic_pkg::*;
#(
  parameter int unsigned R     = 4,
  parameter int unsigned N     = 3,
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 40
) (
  input logic                      clk,
  input logic                      rst,
  cic_upsample_integrator_if.slave bus
);

  localparam int unsigned       PH_W      = $clog2(R);
  localparam int unsigned       FILL_W    = $clog2(N + 1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(R - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
  localparam logic [FILL_W-1:0] FILL_PRE  = FILL_W'(N - 1);

  cic_state_e              state_r;
  cic_state_e              state_nxt_s;
  logic [PH_W-1:0]         phase_r;
  logic [PH_W-1:0]         phase_nxt_s;
  logic [FILL_W-1:0]       fill_r;
  logic [FILL_W-1:0]       fill_nxt_s;
  logic                    out_valid_r;
  logic                    out_valid_nxt_s;

  logic                    phase_zero_s;
  logic                    out_free_s;
  logic                    adv_s;
  logic                    in_ready_s;
  logic                    running_s;
  logic signed [IN_W-1:0]  d_in_s;
  logic signed [OUT_W-1:0] inject_s;

  logic signed [OUT_W-1:0] addend_s [N];
  logic signed [OUT_W-1:0] acc_s    [N];

  assign d_in_s = bus.d_in;

  // Handshake, advance decision and zero-stuffed injection value.
  always_comb begin
    phase_zero_s = (phase_r == {PH_W{1'b0}});
    out_free_s   = ~out_valid_r | bus.out_ready;
    // At phase 0 the chain needs a real sample; never substitute zeros.
    adv_s        = out_free_s & (~phase_zero_s | bus.in_valid);
    // Held low during reset; independent of in_valid by construction.
    in_ready_s   = rst & phase_zero_s & out_free_s;
    if (phase_zero_s) begin
      inject_s = OUT_W'($signed(d_in_s));
    end else begin
      inject_s = {OUT_W{1'b0}};
    end
  end

  // FSM, phase and fill next-state; everything moves only on advance.
  always_comb begin
    state_nxt_s     = state_r;
    phase_nxt_s     = phase_r;
    fill_nxt_s      = fill_r;
    out_valid_nxt_s = out_valid_r;
    case (state_r)
      ST_IDLE: begin
        // In IDLE an advance can only come from an accepted sample.
        if (adv_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        state_nxt_s = ST_RUN;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    if (adv_s) begin
      if (phase_r == PH_LAST) begin
        phase_nxt_s = {PH_W{1'b0}};
      end else begin
        phase_nxt_s = phase_r + PH_W'(1);
      end
      if (fill_r != FILL_FULL) begin
        fill_nxt_s = fill_r + FILL_W'(1);
      end else begin
        fill_nxt_s = fill_r;
      end
      // Valid rises when the first sample has crossed all N stages.
      if (fill_r == FILL_PRE) begin
        out_valid_nxt_s = 1'b1;
      end else begin
        out_valid_nxt_s = out_valid_r;
      end
    end else begin
      phase_nxt_s     = phase_r;
      fill_nxt_s      = fill_r;
      out_valid_nxt_s = out_valid_r;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      phase_r     <= {PH_W{1'b0}};
      fill_r      <= {FILL_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      phase_r     <= phase_nxt_s;
      fill_r      <= fill_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

  // Integrator cascade: stage 0 takes the stuffed input, stage k the
  // registered output of stage k-1.
  for (genvar k = 0; k < N; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign addend_s[k] = inject_s;
    end else begin : g_next
      assign addend_s[k] = acc_s[k-1];
    end
    cic_integrator_stage #(
      .W (OUT_W)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .adv    (adv_s),
      .addend (addend_s[k]),
      .acc    (acc_s[k])
    );
  end

  assign bus.d_out     = acc_s[N-1];
  assign bus.out_valid = out_valid_r;
  assign bus.in_ready  = in_ready_s;
  assign running_s     = (state_r == ST_RUN);

  cic_upsample_integrator_chk #(
    .OUT_W (OUT_W)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .out_valid  (out_valid_r),
    .out_ready  (bus.out_ready),
    .in_ready   (in_ready_s),
    .phase_zero (phase_zero_s),
    .running    (running_s),
    .d_out      (acc_s[N-1])
  );

endmodule

// File: tb/tb_cic_upsample_integrator.sv
// Directed bench for the CIC integrator section: four configurations
// (impulse with stall, step, underrun, 8-bit wrap) driven from a vector
// table, plus a hand-written mid-stream reset sequence.
module tb_cic_upsample_integrator;

  logic clk;
  logic rst;

  cic_upsample_integrator_if #(.IN_W(32), .OUT_W(40)) bus_a ();
  cic_upsample_integrator_if #(.IN_W(32), .OUT_W(40)) bus_b ();
  cic_upsample_integrator_if #(.IN_W(32), .OUT_W(40)) bus_c ();
  cic_upsample_integrator_if #(.IN_W(8),  .OUT_W(8))  bus_d ();

  cic_upsample_integrator #(.R(2), .N(3), .IN_W(32), .OUT_W(40)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a));
  cic_upsample_integrator #(.R(2), .N(1), .IN_W(32), .OUT_W(40)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b));
  cic_upsample_integrator #(.R(4), .N(1), .IN_W(32), .OUT_W(40)) dut_c (
    .clk (clk), .rst (rst), .bus (bus_c));
  cic_upsample_integrator #(.R(2), .N(1), .IN_W(8), .OUT_W(8)) dut_d (
    .clk (clk), .rst (rst), .bus (bus_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                 dut;
    logic               iv;
    logic signed [39:0] din;
    logic               ordy;
    logic               eov;
    logic signed [39:0] edout;
    logic               eirdy;
  } vec_t;

  vec_t tbl[$];
  int   passed = 0;
  int   total  = 0;

  function automatic void add(input int dut, input logic iv,
                              input logic signed [39:0] din, input logic ordy,
                              input logic eov, input logic signed [39:0] edout,
                              input logic eirdy);
    vec_t v;
    v.dut = dut; v.iv = iv; v.din = din; v.ordy = ordy;
    v.eov = eov; v.edout = edout; v.eirdy = eirdy;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input int idx,
                       input logic signed [39:0] act, input logic signed [39:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
  endtask

  // Drive one DUT; all others sit idle (no valid, no ready).
  task automatic drive(input int dut, input logic iv,
                       input logic signed [39:0] din, input logic ordy);
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0; bus_a.d_in = 32'sd0;
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0; bus_b.d_in = 32'sd0;
    bus_c.in_valid = 1'b0; bus_c.out_ready = 1'b0; bus_c.d_in = 32'sd0;
    bus_d.in_valid = 1'b0; bus_d.out_ready = 1'b0; bus_d.d_in = 8'sd0;
    case (dut)
      0: begin bus_a.in_valid = iv; bus_a.d_in = din[31:0]; bus_a.out_ready = ordy; end
      1: begin bus_b.in_valid = iv; bus_b.d_in = din[31:0]; bus_b.out_ready = ordy; end
      2: begin bus_c.in_valid = iv; bus_c.d_in = din[31:0]; bus_c.out_ready = ordy; end
      3: begin bus_d.in_valid = iv; bus_d.d_in = din[7:0];  bus_d.out_ready = ordy; end
      default: ;
    endcase
  endtask

  task automatic sample(input int dut, output logic ov,
                        output logic signed [39:0] dout, output logic irdy);
    case (dut)
      0: begin ov = bus_a.out_valid; dout = bus_a.d_out; irdy = bus_a.in_ready; end
      1: begin ov = bus_b.out_valid; dout = bus_b.d_out; irdy = bus_b.in_ready; end
      2: begin ov = bus_c.out_valid; dout = bus_c.d_out; irdy = bus_c.in_ready; end
      default: begin ov = bus_d.out_valid; dout = 40'(bus_d.d_out); irdy = bus_d.in_ready; end
    endcase
  endtask

  // Apply one table row after a rising edge and check before the next one.
  task automatic run_row(input int i, input string pfx);
    logic               ov;
    logic signed [39:0] dout;
    logic               irdy;
    string              n;
    @(posedge clk); #1;
    drive(tbl[i].dut, tbl[i].iv, tbl[i].din, tbl[i].ordy);
    @(negedge clk);
    sample(tbl[i].dut, ov, dout, irdy);
    case (tbl[i].dut)
      0: n = "impulse";
      1: n = "step";
      2: n = "underrun";
      default: n = "wrap";
    endcase
    n = {pfx, n};
    check({n, ".out_valid"}, i, 40'(ov),   40'(tbl[i].eov));
    check({n, ".d_out"},     i, dout,      tbl[i].edout);
    check({n, ".in_ready"},  i, 40'(irdy), 40'(tbl[i].eirdy));
  endtask

  initial begin
    logic               ov;
    logic signed [39:0] dout;
    logic               irdy;

    // Impulse, R=2 N=3: d_in = 1 then 0; 5-cycle stall after d_out reaches 21.
    add(0, 1'b1, 40'sd1, 1'b1, 1'b0, 40'sd0,  1'b1);
    add(0, 1'b1, 40'sd0, 1'b1, 1'b0, 40'sd0,  1'b0);
    add(0, 1'b1, 40'sd0, 1'b1, 1'b0, 40'sd0,  1'b1);
    add(0, 1'b1, 40'sd0, 1'b1, 1'b1, 40'sd1,  1'b0);
    add(0, 1'b1, 40'sd0, 1'b1, 1'b1, 40'sd3,  1'b1);
    add(0, 1'b1, 40'sd0, 1'b1, 1'b1, 40'sd6,  1'b0);
    add(0, 1'b1, 40'sd0, 1'b1, 1'b1, 40'sd10, 1'b1);
    add(0, 1'b1, 40'sd0, 1'b1, 1'b1, 40'sd15, 1'b0);
    for (int k = 0; k < 5; k++) add(0, 1'b1, 40'sd0, 1'b0, 1'b1, 40'sd21, 1'b0);
    add(0, 1'b1, 40'sd0, 1'b1, 1'b1, 40'sd21, 1'b1);
    add(0, 1'b1, 40'sd0, 1'b1, 1'b1, 40'sd28, 1'b0);
    add(0, 1'b1, 40'sd0, 1'b1, 1'b1, 40'sd36, 1'b1);
    add(0, 1'b1, 40'sd0, 1'b1, 1'b1, 40'sd45, 1'b0);
    // Step, R=2 N=1: d_in = 1 constant.
    add(1, 1'b1, 40'sd1, 1'b1, 1'b0, 40'sd0, 1'b1);
    add(1, 1'b1, 40'sd1, 1'b1, 1'b1, 40'sd1, 1'b0);
    add(1, 1'b1, 40'sd1, 1'b1, 1'b1, 40'sd1, 1'b1);
    add(1, 1'b1, 40'sd1, 1'b1, 1'b1, 40'sd2, 1'b0);
    add(1, 1'b1, 40'sd1, 1'b1, 1'b1, 40'sd2, 1'b1);
    add(1, 1'b1, 40'sd1, 1'b1, 1'b1, 40'sd3, 1'b0);
    add(1, 1'b1, 40'sd1, 1'b1, 1'b1, 40'sd3, 1'b1);
    // Underrun, R=4 N=1: in_valid dropped for 3 cycles at phase 0.
    add(2, 1'b1, 40'sd1, 1'b1, 1'b0, 40'sd0, 1'b1);
    for (int k = 0; k < 3; k++) add(2, 1'b1, 40'sd1, 1'b1, 1'b1, 40'sd1, 1'b0);
    for (int k = 0; k < 3; k++) add(2, 1'b0, 40'sd1, 1'b1, 1'b1, 40'sd1, 1'b1);
    add(2, 1'b1, 40'sd1, 1'b1, 1'b1, 40'sd1, 1'b1);
    for (int k = 0; k < 3; k++) add(2, 1'b1, 40'sd1, 1'b1, 1'b1, 40'sd2, 1'b0);
    add(2, 1'b1, 40'sd1, 1'b1, 1'b1, 40'sd2, 1'b1);
    add(2, 1'b1, 40'sd1, 1'b1, 1'b1, 40'sd3, 1'b0);
    // Wrap, 8-bit, R=2 N=1: d_in = 127 constant.
    add(3, 1'b1, 40'sd127, 1'b1, 1'b0, 40'sd0,   1'b1);
    add(3, 1'b1, 40'sd127, 1'b1, 1'b1, 40'sd127, 1'b0);
    add(3, 1'b1, 40'sd127, 1'b1, 1'b1, 40'sd127, 1'b1);
    add(3, 1'b1, 40'sd127, 1'b1, 1'b1, -40'sd2,  1'b0);
    add(3, 1'b1, 40'sd127, 1'b1, 1'b1, -40'sd2,  1'b1);
    add(3, 1'b1, 40'sd127, 1'b1, 1'b1, 40'sd125, 1'b0);

    rst = 1'b0;
    drive(9, 1'b0, 40'sd0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_row(i, "");

    // Impulse DUT finished its last row with one more advance (45 -> 55)
    // and has held since, with out_ready low.
    @(posedge clk); #1;
    drive(9, 1'b0, 40'sd0, 1'b0);
    @(negedge clk);
    sample(0, ov, dout, irdy);
    check("impulse.hold_before_rst.d_out", 0, dout, 40'sd55);
    check("impulse.hold_before_rst.out_valid", 0, 40'(ov), 40'sd1);

    // Mid-stream reset: outputs clear at once, in_ready low despite out_ready.
    @(posedge clk); #1;
    drive(0, 1'b0, 40'sd0, 1'b1);
    rst = 1'b0;
    #2;
    sample(0, ov, dout, irdy);
    check("rst.out_valid", 0, 40'(ov),   40'sd0);
    check("rst.d_out",     0, dout,      40'sd0);
    check("rst.in_ready",  0, 40'(irdy), 40'sd0);
    sample(3, ov, dout, irdy);
    check("rst.wrap_d_out", 0, dout, 40'sd0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(9, 1'b0, 40'sd0, 1'b0);

    // Fresh impulse after reset reproduces the fill and 1, 3, 6, 10.
    for (int i = 0; i < 7; i++) run_row(i, "replay.");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
